// File: rtl/clock_enable_gen.sv
// -----------------------------------------------------------------------------
// clock_enable_gen
//
// Generates NUM_CH single-cycle clock-enable streams from one reference clock.
// Each channel has a programmable divide ratio and phase. After reset or after
// any accepted channel reconfiguration, the block waits LOCK_CYCLES cycles with
// every enable held low. It then starts all channel counters together, so every
// channel is phase-aligned to the same lock instant.
//
// Ports
//   refclk     in   1        only clock
//   rst        in   1        synchronous, active-high reset (highest priority)
//   cfg_valid  in   1        configuration write offered
//   cfg_ready  out  1        configuration write can be accepted (== locked)
//   cfg_ch     in   CH_W     target channel; out-of-range writes are dropped
//   cfg_div    in   DIV_W    divide ratio (0 behaves as 1)
//   cfg_phase  in   DIV_W    enable phase (clamped to divide-1 on use)
//   ce_out     out  NUM_CH   per-channel single-cycle clock enables
//   locked     out  1        all channels running and phase-aligned
// -----------------------------------------------------------------------------
module clock_enable_gen #(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 8,
    parameter int LOCK_CYCLES = 16,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] ce_out,
    output logic              locked
);

    typedef enum logic [0:0] {
        ST_SETTLE = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // One extra bit so NUM_CH itself is representable for the range check.
    localparam logic [CH_W:0]  NUM_CH_L   = (CH_W + 1)'(NUM_CH);
    localparam logic [15:0]    SETTLE_RLD = 16'(LOCK_CYCLES);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);

    // Effective divide: a stored 0 behaves as 1.
    function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
        logic [DIV_W-1:0] r;
        if (d == DIV_ZERO) begin
            r = DIV_ONE;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Effective phase: clamp to the last count of the effective period.
    function automatic logic [DIV_W-1:0] eff_phase(input logic [DIV_W-1:0] d,
                                                   input logic [DIV_W-1:0] p);
        logic [DIV_W-1:0] last;
        logic [DIV_W-1:0] r;
        last = eff_div(d) - DIV_ONE;
        if (p > last) begin
            r = last;
        end else begin
            r = p;
        end
        return r;
    endfunction

    state_t                         state_q, state_d;
    logic [15:0]                    settle_q, settle_d;
    logic [NUM_CH-1:0][DIV_W-1:0]   cnt_q, cnt_d;
    logic [NUM_CH-1:0][DIV_W-1:0]   div_q, div_d;
    logic [NUM_CH-1:0][DIV_W-1:0]   phase_q, phase_d;

    logic locked_s;
    logic accept_s;
    logic ch_ok_s;

    assign locked_s  = (state_q == ST_LOCKED);
    assign accept_s  = cfg_valid & locked_s;
    assign ch_ok_s   = ({1'b0, cfg_ch} < NUM_CH_L);
    assign locked    = locked_s;
    assign cfg_ready = locked_s;

    // State, settle counter, channel counters and channel configuration registers.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q  <= ST_SETTLE;
            settle_q <= SETTLE_RLD;
            cnt_q    <= '{default: DIV_ZERO};
            div_q    <= '{default: DIV_ONE};
            phase_q  <= '{default: DIV_ZERO};
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            phase_q  <= phase_d;
        end
    end

    // Next-state logic: settle countdown, channel counting, and config writes.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        phase_d  = phase_q;

        case (state_q)
            ST_SETTLE: begin
                // Counters stay at 0 so all channels start aligned on lock.
                cnt_d = '{default: DIV_ZERO};
                if (settle_q <= 16'd1) begin
                    state_d  = ST_LOCKED;
                    settle_d = 16'd0;
                end else begin
                    settle_d = settle_q - 16'd1;
                end
            end
            ST_LOCKED: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    // >= rather than == so a shrunk divide can never strand a counter.
                    if (cnt_q[c] >= (eff_div(div_q[c]) - DIV_ONE)) begin
                        cnt_d[c] = DIV_ZERO;
                    end else begin
                        cnt_d[c] = cnt_q[c] + DIV_ONE;
                    end
                end
                if (accept_s && ch_ok_s) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (cfg_ch == CH_W'(c)) begin
                            div_d[c]   = cfg_div;
                            phase_d[c] = cfg_phase;
                        end else begin
                            div_d[c]   = div_q[c];
                            phase_d[c] = phase_q[c];
                        end
                    end
                    state_d  = ST_SETTLE;
                    settle_d = SETTLE_RLD;
                    cnt_d    = '{default: DIV_ZERO};
                end else begin
                    // Out-of-range channel or no write: the write is dropped and counting continues.
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d  = ST_SETTLE;
                settle_d = SETTLE_RLD;
                cnt_d    = '{default: DIV_ZERO};
            end
        endcase
    end

    // Zero-latency enable decode from registered counters and configuration.
    always_comb begin
        ce_out = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (locked_s && (cnt_q[c] == eff_phase(div_q[c], phase_q[c]))) begin
                ce_out[c] = 1'b1;
            end else begin
                ce_out[c] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clock_enable_gen.sv
// -----------------------------------------------------------------------------
// tb_clock_enable_gen
//
// Drives clock_enable_gen with directed and random configuration traffic and
// compares locked / cfg_ready / ce_out every cycle against a behavioural model.
// The model tracks the time since lock and derives each enable as
// (time mod D) == P.
// -----------------------------------------------------------------------------
module tb_clock_enable_gen;

    localparam int NUM_CH      = 2;
    localparam int DIV_W       = 8;
    localparam int LOCK_CYCLES = 16;
    localparam int CH_W        = 2;   // wide enough to address a missing channel

    logic              refclk = 1'b0;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic [DIV_W-1:0]  cfg_phase;
    logic [NUM_CH-1:0] ce_out;
    logic              locked;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int m_locked = 0;
    int m_rem    = LOCK_CYCLES;
    int m_t      = 0;
    int m_acc    = 0;
    int m_div   [NUM_CH];
    int m_phase [NUM_CH];

    clock_enable_gen #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .LOCK_CYCLES (LOCK_CYCLES),
        .CH_W        (CH_W)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_phase (cfg_phase),
        .ce_out    (ce_out),
        .locked    (locked)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model update for one rising edge, using the inputs currently driven.
    task automatic model_edge();
        m_acc = 0;
        if (rst) begin
            m_locked = 0;
            m_rem    = LOCK_CYCLES;
            m_t      = 0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_div[c]   = 1;
                m_phase[c] = 0;
            end
        end else if (m_locked == 0) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                m_locked = 1;
                m_t      = 0;
            end
        end else if (cfg_valid) begin
            m_acc = 1;
            if (int'(cfg_ch) < NUM_CH) begin
                m_div[int'(cfg_ch)]   = int'(cfg_div);
                m_phase[int'(cfg_ch)] = int'(cfg_phase);
                m_locked = 0;
                m_rem    = LOCK_CYCLES;
            end else begin
                m_t = m_t + 1;
            end
        end else begin
            m_t = m_t + 1;
        end
    endtask

    function automatic logic [NUM_CH-1:0] model_ce();
        logic [NUM_CH-1:0] r;
        int d;
        int p;
        r = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            d = (m_div[c] == 0) ? 1 : m_div[c];
            p = (m_phase[c] > d - 1) ? d - 1 : m_phase[c];
            r[c] = (m_locked != 0) && ((m_t % d) == p);
        end
        return r;
    endfunction

    task automatic step();
        @(posedge refclk);
        model_edge();
        #1;
        check("locked",    32'(locked),    32'(m_locked));
        check("cfg_ready", 32'(cfg_ready), 32'(m_locked));
        check("ce_out",    32'(ce_out),    32'(model_ce()));
    endtask

    // Offer a write and hold it until the model says it was taken (bounded).
    task automatic write_hold(input int ch, input int dv, input int ph, input int max_cyc);
        int n;
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_div   = DIV_W'(dv);
        cfg_phase = DIV_W'(ph);
        n = 0;
        while (n < max_cyc) begin
            step();
            n++;
            if (m_acc != 0) break;
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        for (int c = 0; c < NUM_CH; c++) begin
            m_div[c]   = 1;
            m_phase[c] = 0;
        end
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        cfg_phase = '0;

        // Reset state
        repeat (3) step();

        // Release: lock after exactly LOCK_CYCLES edges, then both enables constant
        rst = 1'b0;
        repeat (22) step();

        // ch1 div=4 phase=1
        write_hold(1, 4, 1, 40);
        repeat (30) step();

        // ch0 div=0 phase=7 -> D=1, P=0
        write_hold(0, 0, 7, 40);
        repeat (24) step();

        // ch0 div=3 phase=9 -> P clamped to 2
        write_hold(0, 3, 9, 40);
        repeat (26) step();

        // Valid held through a whole settle period: one accept on first LOCKED cycle
        write_hold(1, 2, 1, 5);
        write_hold(1, 5, 3, 40);
        repeat (20) step();

        // Out-of-range channels: accepted but discarded, no relock
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(3);
        cfg_div   = DIV_W'(7);
        cfg_phase = DIV_W'(0);
        repeat (3) step();
        cfg_ch = CH_W'(2);
        repeat (2) step();
        cfg_valid = 1'b0;
        repeat (8) step();

        // Reset in the same cycle as an accept: reset wins, full settle repeats
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(0);
        cfg_div   = DIV_W'(6);
        cfg_phase = DIV_W'(2);
        rst       = 1'b1;
        step();
        rst       = 1'b0;
        cfg_valid = 1'b0;
        repeat (22) step();

        // Randomized traffic
        repeat (800) begin
            rst       = ($urandom_range(0, 59) == 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = CH_W'($urandom_range(0, 3));
            cfg_div   = DIV_W'($urandom_range(0, 6));
            cfg_phase = DIV_W'($urandom_range(0, 8));
            step();
        end
        rst       = 1'b0;
        cfg_valid = 1'b0;
        repeat (20) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clock_enable_gen.md
CLOCK_ENABLE_GEN -- requirements
Module: clock_enable_gen

Interface
REQ-001 The block SHALL have one clock, `refclk`; reset `rst` is synchronous and active-high, sampled on the rising edge of `refclk`.
REQ-002 Parameter NUM_CH, default 2: number of clock-enable channels, legal range 1..16.
REQ-003 Parameter DIV_W, default 8: width of the divide and phase fields.
REQ-004 Parameter LOCK_CYCLES, default 16: settle time in `refclk` cycles before lock, legal range 1..65535.
REQ-005 Parameter CH_W, default max(1, clog2(NUM_CH)): width of the channel-select field.
REQ-006 Port `refclk`, input, 1 bit: the only clock.
REQ-007 Port `rst`, input, 1 bit: synchronous active-high reset.
REQ-008 Port `cfg_valid`, input, 1 bit: a configuration write is offered.
REQ-009 Port `cfg_ready`, output, 1 bit: the block can accept a configuration write.
REQ-010 Port `cfg_ch`, input, CH_W bits: target channel index.
REQ-011 Port `cfg_div`, input, DIV_W bits: divide ratio.
REQ-012 Port `cfg_phase`, input, DIV_W bits: enable phase within the divide period.
REQ-013 Port `ce_out`, output, NUM_CH bits: per-channel single-cycle clock enables.
REQ-014 Port `locked`, output, 1 bit: all channels are running and phase-aligned.

Function
REQ-015 The FSM SHALL have exactly two states, SETTLE and LOCKED.
REQ-016 In SETTLE: settle counter decrements by 1 per cycle; all channel counters are held at 0; `ce_out` = 0; `locked` = 0; `cfg_ready` = 0.
REQ-017 On the edge where the settle counter is 1, the FSM SHALL move to LOCKED, so that `locked` rises exactly LOCK_CYCLES edges after the first edge with `rst` = 0.
REQ-018 In LOCKED: `locked` = 1 and `cfg_ready` = 1.
REQ-019 In LOCKED, each channel counter c counts 0..D[c]-1 and wraps to 0; all channel counters are 0 in the first LOCKED cycle.
REQ-020 Effective divide D[c] = max(div[c], 1), so a stored divide of 0 behaves as 1.
REQ-021 Effective phase P[c] = min(phase[c], D[c]-1).
REQ-022 ce_out[c] = locked AND (count[c] == P[c]), decoded combinationally from registered state with zero latency; with D = 1, ce_out[c] is constantly 1 while locked.
REQ-023 A configuration write is accepted when cfg_valid AND cfg_ready.
REQ-024 On accept with cfg_ch < NUM_CH: write div[cfg_ch] and phase[cfg_ch] (unclamped), go to SETTLE, reload the settle counter with LOCK_CYCLES, and drop `locked` and `ce_out` on the next cycle.
REQ-025 While cfg_valid is high and cfg_ready is low, nothing SHALL be written, and the requester holds its write.
REQ-026 On accept with cfg_ch >= NUM_CH: the write is discarded, no relock occurs, and the state stays LOCKED.
REQ-027 At most one configuration write is accepted per lock period; a write in the cycle of the LOCKED transition is not accepted because cfg_ready is still 0.
REQ-028 An `ce_out` pulse present in the accept cycle itself SHALL still be output.
REQ-029 Counter widths SHALL be DIV_W for channel counters and 16 bits for the settle counter, with no overflow for legal parameter values.

Reset
REQ-030 `rst` SHALL have priority over every other input, including a configuration accept in the same cycle.
REQ-031 On `rst` = 1: state = SETTLE, settle counter = LOCK_CYCLES, all channel counters = 0, every div = 1, every phase = 0.
REQ-032 During `rst` = 1: `locked` = 0, `cfg_ready` = 0, `ce_out` = 0.
REQ-033 Assertion of `rst` in LOCKED or SETTLE SHALL cause `locked` to fall on the following cycle.

Verification
REQ-034 Defaults (NUM_CH=2, LOCK_CYCLES=16), `rst` released -> `locked` rises on edge 16 after release; from then ce_out = 2'b11 every cycle.
REQ-035 Write ch1 div=4 phase=1 -> `locked` low for 16 cycles; then ce_out[1] high in LOCKED cycles 1, 5, 9, ..., and ce_out[0] constantly 1.
REQ-036 Write ch0 div=0 phase=7 -> after relock, ce_out[0] constantly 1 (D=1, P clamped to 0).
REQ-037 Write ch0 div=3 phase=9 -> P clamped to 2; ce_out[0] high in LOCKED cycles 2, 5, 8.
REQ-038 cfg_valid held high through SETTLE -> exactly one accept, in the first LOCKED cycle; cfg_ch=3 with NUM_CH=2 -> no relock and no change to ce_out.
REQ-039 `rst` asserted mid-LOCKED in the same cycle as an accept -> write ignored, every div back to 1, and the full 16-cycle settle repeats.
